csr_trap_unit: RTL and testbench

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

---
 rtl/csr_trap_unit_pkg.sv | 39 +++
 rtl/csr_counter64.sv | 28 ++
 rtl/csr_trap_unit.sv | 207 ++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit: CSR addresses,
// csr_op encoding, mstatus bit positions and cause encoding.
package csr_trap_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam int CAUSE_INT_BIT = 31;
  localparam int IRQ_BASE      = 16;

  // mie/mip bit mask covering the implemented external lines
  function automatic logic [31:0] irq_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[IRQ_BASE + i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent half writes; a written half
// takes priority over the increment in the same cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {63'd0, inc_i};
    if (wr_lo_i) cnt_d[31:0]  = wdata_i;
    if (wr_hi_i) cnt_d[63:32] = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt/exception entry and mret handling.
// Define CSR_COUNTERS_EN to add the mcycle/minstret counters.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int NUM_IRQ  = 4,
  parameter int VECTORED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               int_req,
  input  logic               int_taken,
  input  logic               exc_taken,
  input  logic [3:0]         exc_cause,
  input  logic [31:0]        exc_tval,
  input  logic [31:0]        pc,
  input  logic               mret,
  input  logic               retire,
  output logic [31:0]        trap_vec,
  output logic [31:0]        csr_mepc
);

  localparam logic [31:0] IRQ_MASK   = irq_mask(NUM_IRQ);
  localparam logic [31:0] MTVEC_MASK = (VECTORED != 0) ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0]        mie_q, mie_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [31:0]        mtval_q, mtval_d;
  logic [NUM_IRQ-1:0] mip_q;

  logic [31:0] mstatus_rd, mip_rd, pend, wval, tvec_base;
  logic [4:0]  irq_cause;
  logic        impl, csr_we;
  csr_op_e     op;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`endif

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_rd               = '0;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
    mip_rd                   = '0;
    mip_rd[IRQ_BASE +: NUM_IRQ] = mip_q;
  end

  assign pend    = mie_q & mip_rd;
  assign int_req = mstatus_mie_q & (|pend);

  // Lowest-index pending+enabled line wins the cause code
  always_comb begin
    irq_cause = 5'(IRQ_BASE);
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[IRQ_BASE + i]) irq_cause = 5'(IRQ_BASE + i);
  end

  always_comb begin
    csr_rdata = '0;
    impl      = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP:       csr_rdata = mip_rd;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
`endif
      default:       impl = 1'b0;
    endcase
  end

  assign csr_illegal = (op != CSR_OP_NONE) && !impl;

  always_comb begin
    case (op)
      CSR_OP_WRITE: wval = csr_wdata;
      CSR_OP_SET:   wval = csr_rdata | csr_wdata;
      CSR_OP_CLEAR: wval = csr_rdata & ~csr_wdata;
      default:      wval = csr_rdata;
    endcase
  end

  // Any trap entry or return in the same cycle squashes the CSR write
  assign csr_we = (op != CSR_OP_NONE) && impl && !(exc_taken || int_taken || mret);

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (exc_taken) begin
      mepc_d         = pc & 32'hFFFF_FFFC;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mcause_d       = {28'd0, exc_cause};
      mtval_d        = exc_tval;
    end else if (int_taken) begin
      mepc_d         = pc & 32'hFFFF_FFFC;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mcause_d       = {1'b1, 26'd0, irq_cause};
      mtval_d        = '0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wval[MSTATUS_MIE];
          mstatus_mpie_d = wval[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wval & IRQ_MASK;
        CSR_MTVEC:    mtvec_d    = wval & MTVEC_MASK;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval & 32'hFFFF_FFFC;
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mip_q          <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mip_q          <= irq;
    end
  end

  assign tvec_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    trap_vec = tvec_base;
    if (VECTORED != 0 && mtvec_q[1:0] == 2'b01 && mcause_q[CAUSE_INT_BIT])
      trap_vec = tvec_base + {25'd0, mcause_q[4:0], 2'b00};
  end

  assign csr_mepc = mepc_q;

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && csr_addr == CSR_MCYCLE),
    .wr_hi_i (csr_we && csr_addr == CSR_MCYCLEH),
    .wdata_i (wval),
    .cnt_o   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (retire),
    .wr_lo_i (csr_we && csr_addr == CSR_MINSTRET),
    .wr_hi_i (csr_we && csr_addr == CSR_MINSTRETH),
    .wdata_i (wval),
    .cnt_o   (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed + randomized bench for csr_trap_unit against a behavioural model.
// Counter checks follow CSR_COUNTERS_EN.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [11:0] addr, addr_b;
  logic [31:0] wdata;
  logic [3:0]  irq;
  logic        int_taken, exc_taken, mret, retire;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval, pc;

  logic [31:0] rdata, rdata_b, trap_vec, trap_vec_b, mepc, mepc_b;
  logic        illegal, illegal_b, int_req, int_req_b;

  int nvec = 0;
  int nerr = 0;

  // behavioural model state
  logic        m_mie_b, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [3:0]  m_mip;
  logic [63:0] m_cyc, m_ins;

  logic [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7FF};

  always #5 clk = ~clk;

  csr_trap_unit #(.NUM_IRQ(4), .VECTORED(1)) u_dut (
    .clk(clk), .rst(rst), .csr_op(op), .csr_addr(addr), .csr_wdata(wdata),
    .csr_rdata(rdata), .csr_illegal(illegal), .irq(irq), .int_req(int_req),
    .int_taken(int_taken), .exc_taken(exc_taken), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .pc(pc), .mret(mret), .retire(retire),
    .trap_vec(trap_vec), .csr_mepc(mepc)
  );

  csr_trap_unit #(.NUM_IRQ(4), .VECTORED(0)) u_dut_nv (
    .clk(clk), .rst(rst), .csr_op(op), .csr_addr(addr_b), .csr_wdata(wdata),
    .csr_rdata(rdata_b), .csr_illegal(illegal_b), .irq(irq), .int_req(int_req_b),
    .int_taken(int_taken), .exc_taken(exc_taken), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .pc(pc), .mret(mret), .retire(retire),
    .trap_vec(trap_vec_b), .csr_mepc(mepc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 24'd0, m_mpie, 3'd0, m_mie_b, 3'd0};
      12'h304: return {1'b1, m_mie};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h343: return {1'b1, m_mtval};
      12'h344: return {1'b1, 12'd0, m_mip, 16'd0};
`ifdef CSR_COUNTERS_EN
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hB02: return {1'b1, m_ins[31:0]};
      12'hB82: return {1'b1, m_ins[63:32]};
`endif
      default: return 33'd0;
    endcase
  endfunction

  function automatic logic m_ireq();
    return m_mie_b && ((m_mie[19:16] & m_mip) != 4'd0);
  endfunction

  function automatic logic [31:0] m_tvec(input bit vect);
    logic [31:0] base;
    base = m_mtvec & 32'hFFFF_FFFC;
    if (vect && m_mtvec[1:0] == 2'b01 && m_mcause[31]) return base + 32'(m_mcause[4:0]) * 4;
    return base;
  endfunction

  task automatic model_reset();
    m_mie_b = 0; m_mpie = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
  endtask

  // Applies the architectural effect of the current inputs at a clock edge
  task automatic model_step();
    logic [32:0] r;
    logic [31:0] w;
    logic [63:0] nc, ni;
    logic        wr, found;
    int          idx;
    if (rst) begin model_reset(); return; end
    r = mread(addr);
    case (op)
      2'b01:   w = wdata;
      2'b10:   w = r[31:0] | wdata;
      2'b11:   w = r[31:0] & ~wdata;
      default: w = r[31:0];
    endcase
    wr = (op != 2'b00) && r[32] && !exc_taken && !int_taken && !mret;
    nc = m_cyc + 64'd1;
    ni = m_ins + (retire ? 64'd1 : 64'd0);
    if (exc_taken) begin
      m_mepc = pc & ~32'h3; m_mpie = m_mie_b; m_mie_b = 0;
      m_mcause = {28'd0, exc_cause}; m_mtval = exc_tval;
    end else if (int_taken) begin
      idx = 0; found = 0;
      for (int i = 0; i < 4; i++)
        if (!found && m_mie[16+i] && m_mip[i]) begin idx = i; found = 1; end
      m_mepc = pc & ~32'h3; m_mpie = m_mie_b; m_mie_b = 0;
      m_mcause = 32'h8000_0000 | 32'(16 + idx); m_mtval = 0;
    end else if (mret) begin
      m_mie_b = m_mpie; m_mpie = 1;
    end else if (wr) begin
      case (addr)
        12'h300: begin m_mie_b = w[3]; m_mpie = w[7]; end
        12'h304: m_mie = w & 32'h000F_0000;
        12'h305: m_mtvec = w & 32'hFFFF_FFFD;
        12'h340: m_mscratch = w;
        12'h341: m_mepc = w & ~32'h3;
        12'h342: m_mcause = w;
        12'h343: m_mtval = w;
        12'hB00: nc[31:0] = w;
        12'hB80: nc[63:32] = w;
        12'hB02: ni[31:0] = w;
        12'hB82: ni[63:32] = w;
        default: ;
      endcase
    end
    m_cyc = nc; m_ins = ni; m_mip = irq;
  endtask

  // Check every observable output against the model, then advance one clock
  task automatic tick();
    logic [32:0] r;
    #1;
    r = mread(addr);
    chk("rdata", rdata, r[31:0]);
    chk("illegal", {31'd0, illegal}, {31'd0, (op != 2'b00) && !r[32]});
    chk("int_req", {31'd0, int_req}, {31'd0, m_ireq()});
    chk("trap_vec", trap_vec, m_tvec(1'b1));
    chk("trap_vec_nv", trap_vec_b, m_tvec(1'b0));
    chk("mepc", mepc, m_mepc);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drv(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
    op = o; addr = a; addr_b = a; wdata = d;
  endtask

  initial begin
    rst = 1; drv(2'b00, 12'h300, 32'd0);
    irq = 0; int_taken = 0; exc_taken = 0; mret = 0; retire = 0;
    exc_cause = 0; exc_tval = 0; pc = 0;
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 0;
    #1 chk("reset_int_req", {31'd0, int_req}, 32'd0);
    chk("reset_mstatus", rdata, 32'd0);

    // mtvec with MODE bit, both VECTORED builds
    drv(2'b01, 12'h305, 32'h8000_0101); tick();
    drv(2'b00, 12'h305, 32'd0);
    #1 chk("mtvec_vec", rdata, 32'h8000_0101);
    chk("mtvec_novec", rdata_b, 32'h8000_0100);
    tick();

    // enable and raise irq[1]
    drv(2'b10, 12'h300, 32'h8); tick();
    drv(2'b10, 12'h304, 32'h0002_0000); tick();
    drv(2'b00, 12'h300, 32'd0); irq = 4'b0010;
    #1 chk("irq_same_cycle", {31'd0, int_req}, 32'd0);
    tick();
    chk("irq_int_req", {31'd0, int_req}, 32'd1);

    // take the interrupt
    int_taken = 1; pc = 32'h100; tick(); int_taken = 0;
    drv(2'b00, 12'h342, 32'd0);
    #1 chk("int_mepc", mepc, 32'h100);
    chk("int_mcause", rdata, 32'h8000_0011);
    chk("int_tvec_vec", trap_vec, 32'h8000_0144);
    chk("int_tvec_novec", trap_vec_b, 32'h8000_0100);
    tick();
    drv(2'b00, 12'h300, 32'd0);
    #1 chk("int_mstatus", rdata, 32'h80);
    tick();

    // mret squashes a concurrent csrrw
    mret = 1; drv(2'b01, 12'h340, 32'h1234); tick(); mret = 0;
    drv(2'b00, 12'h300, 32'd0);
    #1 chk("mret_mstatus", rdata, 32'h88);
    tick();
    drv(2'b00, 12'h340, 32'd0);
    #1 chk("mret_drop_write", rdata, 32'd0);
    tick();

    // exception beats interrupt
    exc_taken = 1; int_taken = 1; exc_cause = 4'd2; exc_tval = 32'hDEAD; pc = 32'h200;
    tick(); exc_taken = 0; int_taken = 0;
    drv(2'b00, 12'h342, 32'd0);
    #1 chk("exc_mcause", rdata, 32'd2);
    chk("exc_mepc", mepc, 32'h200);
    chk("exc_tvec", trap_vec, 32'h8000_0100);
    tick();
    drv(2'b00, 12'h343, 32'd0);
    #1 chk("exc_mtval", rdata, 32'hDEAD);
    tick();

    // set then clear MIE
    drv(2'b10, 12'h300, 32'h8); tick();
    drv(2'b00, 12'h300, 32'd0);
    #1 chk("set_mie", rdata, 32'h88);
    tick();
    drv(2'b11, 12'h300, 32'h8);
    #1 chk("clear_prewrite", rdata, 32'h88);
    tick();
    drv(2'b00, 12'h300, 32'd0);
    #1 chk("clear_mie", rdata, 32'h80);
    tick();

    // unimplemented address
    drv(2'b10, 12'h7FF, 32'd0);
    #1 chk("illegal_flag", {31'd0, illegal}, 32'd1);
    chk("illegal_rdata", rdata, 32'd0);
    tick();

    // mepc low bits and mip are not writable
    drv(2'b01, 12'h341, 32'h303); tick();
    drv(2'b00, 12'h341, 32'd0);
    #1 chk("mepc_lowbits", rdata, 32'h300);
    tick();
    drv(2'b01, 12'h344, 32'hFFFF_FFFF);
    #1 chk("mip_legal", {31'd0, illegal}, 32'd0);
    tick();
    drv(2'b00, 12'h344, 32'd0);
    #1 chk("mip_ro", rdata, 32'h0002_0000);
    tick();

`ifdef CSR_COUNTERS_EN
    drv(2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    drv(2'b00, 12'hB00, 32'd0); addr_b = 12'hB80;
    #1 chk("mcycle_lo_written", rdata, 32'hFFFF_FFFF);
    chk("mcycle_hi_before", rdata_b, 32'd0);
    tick();
    chk("mcycle_lo_wrap", rdata, 32'd0);
    chk("mcycle_hi_carry", rdata_b, 32'd1);
    drv(2'b00, 12'hB02, 32'd0); addr_b = 12'hB82;
    #1 chk("minstret_idle", rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      retire = 1; tick(); retire = 0; tick(); tick();
    end
    chk("minstret_count", rdata, 32'd3);
    chk("minstret_hi", rdata_b, 32'd0);
    tick();
`else
    drv(2'b10, 12'hB00, 32'd0);
    #1 chk("mcycle_absent", {31'd0, illegal}, 32'd1);
    tick();
    drv(2'b01, 12'hB82, 32'd5);
    #1 chk("minstreth_absent", {31'd0, illegal}, 32'd1);
    tick();
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drv(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 12)], $urandom);
      rst       = ($urandom_range(0, 63) == 0);
      irq       = 4'($urandom);
      exc_taken = ($urandom_range(0, 15) == 0);
      int_taken = ($urandom_range(0, 5) == 0) && m_ireq();
      mret      = ($urandom_range(0, 15) == 0);
      retire    = 1'($urandom);
      exc_cause = 4'($urandom);
      exc_tval  = $urandom;
      pc        = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        drv(2'b10, 12'h300, 32'h8);
        rst = 0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
